// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter: opcodes and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// 4-bit ALU working on 5-bit zero-extended operands; result is 5 bits wide.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [4:0] result
);

    logic [4:0] ea;
    logic [4:0] eb;

    assign ea = {1'b0, a};
    assign eb = {1'b0, b};

    // Decode the opcode; SUB wraps mod 32, NOT sets bit 4, shifts move by one place.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = ea + eb;
            OP_SUB:  result = ea - eb;
            OP_AND:  result = ea & eb;
            OP_OR:   result = ea | eb;
            OP_XOR:  result = ea ^ eb;
            OP_NOT:  result = ~ea;
            OP_SHL:  result = ea << 1;
            OP_SHR:  result = ea >> 1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters.
// Requests are accepted in IDLE, executed for one cycle, then the response
// is held until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0]   req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4:0]           rsp_result,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   grant_nxt;
    logic [ID_W-1:0]   id_r;
    logic [3:0]        a_r;
    logic [3:0]        b_r;
    logic [2:0]        op_r;
    logic [3:0]        sel_a;
    logic [3:0]        sel_b;
    logic [2:0]        sel_op;
    logic [4:0]        alu_res;

    // First valid index at or after ptr, with wrap-around. The valid vector is
    // doubled and shifted so the scan only ever uses constant bit positions.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  ptr);
        logic [2*N_REQ-1:0] rot;
        logic [ID_W-1:0]    pick;
        logic               found;
        int unsigned        pos;
        rot   = {valid, valid} >> ptr;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && rot[k]) begin
                pick  = ID_W'(pos);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant     = rr_pick(req_valid, rr_ptr);
    assign grant_nxt = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
    assign busy      = (state != ST_IDLE);

    // Grant handshake and operand mux for the winning requester.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                req_ready[i] = (state == ST_IDLE) && (|req_valid);
                sel_a        = req_a[4*i +: 4];
                sel_b        = req_b[4*i +: 4];
                sel_op       = req_op[3*i +: 3];
            end
        end
    end

    alu u_alu (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .result (alu_res)
    );

    // FSM: accept in IDLE, compute in EXEC, hold the response in RESP until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            id_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        a_r    <= sel_a;
                        b_r    <= sel_b;
                        op_r   <= sel_op;
                        id_r   <= grant;
                        rr_ptr <= grant_nxt;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_res;
                    rsp_id     <= id_r;
                    rsp_valid  <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
